// File: rtl/multicycle_core_control_if.sv
// Control bundle between the multi-cycle sequencer and the datapath/memories.
// master = sequencer side, slave = datapath/memory side.
interface multicycle_core_control_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode_i;
  logic             imem_ready_i;
  logic             dmem_ready_i;
  logic             fetch_req_o;
  logic             ir_write;
  logic             pc_write;
  logic             branch;
  logic             jal;
  logic             jalr;
  logic             memread;
  logic             memwrite;
  logic             memtoreg;
  logic             regwrite;
  logic [1:0]       aluop;
  logic [1:0]       alusrc;
  logic [2:0]       state_o;
  logic             trap_o;
  logic [1:0]       trap_cause_o;
  logic [CNT_W-1:0] instret_o;

  modport master (
    input  opcode_i, imem_ready_i, dmem_ready_i,
    output fetch_req_o, ir_write, pc_write,
    output branch, jal, jalr,
    output memread, memwrite, memtoreg, regwrite,
    output aluop, alusrc, state_o,
    output trap_o, trap_cause_o, instret_o
  );

  modport slave (
    output opcode_i, imem_ready_i, dmem_ready_i,
    input  fetch_req_o, ir_write, pc_write,
    input  branch, jal, jalr,
    input  memread, memwrite, memtoreg, regwrite,
    input  aluop, alusrc, state_o,
    input  trap_o, trap_cause_o, instret_o
  );
endinterface

// File: rtl/multicycle_core_control.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with
// ready waits, illegal/timeout trapping and a retired-instruction counter.
module multicycle_core_control #(
  parameter bit          ENABLE_UPPER = 1'b1,
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int          CNT_W        = 32
) (
  input logic clk,
  input logic rst,
  multicycle_core_control_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_R, C_I, C_LOAD, C_STORE, C_B,
    C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILL
  } cls_t;

  state_t           state, state_n;
  cls_t             cls, cls_n, dec;
  logic [31:0]      wcnt, wcnt_n;
  logic [1:0]       cause, cause_n;
  logic [CNT_W-1:0] instret;
  logic             tmo;
  logic             in_x;
  logic             pc_wr;

  logic [6:0] op;
  assign op = bus.opcode_i;

  always_comb begin
    dec = C_ILL;
    unique case (1'b1)
      op == 7'b0110011: dec = C_R;
      op == 7'b0010011: dec = C_I;
      op == 7'b0000011: dec = C_LOAD;
      op == 7'b0100011: dec = C_STORE;
      op == 7'b1100011: dec = C_B;
      op == 7'b1101111: dec = C_JAL;
      op == 7'b1100111: dec = C_JALR;
      op == 7'b0110111 && ENABLE_UPPER: dec = C_LUI;
      op == 7'b0010111 && ENABLE_UPPER: dec = C_AUIPC;
      default: dec = C_ILL;
    endcase
  end

  // limit hit on the cycle that would make the wait count reach MEM_TIMEOUT
  assign tmo = (MEM_TIMEOUT != 0) &&
               (wcnt == 32'(MEM_TIMEOUT - 1));

  always_comb begin
    state_n = state;
    cls_n   = cls;
    cause_n = cause;
    wcnt_n  = '0;
    unique case (state)
      S_FETCH: begin
        if (bus.imem_ready_i) begin
          state_n = S_DECODE;
        end else if (tmo) begin
          state_n = S_TRAP;
          cause_n = 2'b10;
        end else begin
          wcnt_n = wcnt + 32'd1;
        end
      end
      S_DECODE: begin
        cls_n = dec;
        if (dec == C_ILL) begin
          state_n = S_TRAP;
          cause_n = 2'b01;
        end else begin
          state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (1'b1)
          cls == C_B: state_n = S_FETCH;
          cls == C_LOAD || cls == C_STORE: state_n = S_MEM;
          default: state_n = S_WB;
        endcase
      end
      S_MEM: begin
        if (bus.dmem_ready_i) begin
          state_n = (cls == C_LOAD) ? S_WB : S_FETCH;
        end else if (tmo) begin
          state_n = S_TRAP;
          cause_n = 2'b11;
        end else begin
          wcnt_n = wcnt + 32'd1;
        end
      end
      S_WB:    state_n = S_FETCH;
      S_TRAP:  state_n = S_TRAP;
      default: state_n = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      cls     <= C_NONE;
      wcnt    <= '0;
      cause   <= '0;
      instret <= '0;
    end else begin
      state <= state_n;
      cls   <= cls_n;
      wcnt  <= wcnt_n;
      cause <= cause_n;
      if (pc_wr) instret <= instret + 1'b1;
    end
  end

  assign in_x = (state == S_EXEC) || (state == S_MEM) ||
                (state == S_WB);

  // Mealy strobes are gated by rst so a reset cycle never commits
  assign pc_wr = !rst && (
    (state == S_EXEC && cls == C_B) ||
    (state == S_MEM && cls == C_STORE && bus.dmem_ready_i) ||
    (state == S_WB));

  always_comb begin
    bus.aluop  = 2'b00;
    bus.alusrc = 2'b00;
    if (in_x) begin
      unique case (1'b1)
        cls == C_R: begin
          bus.aluop = 2'b10;
        end
        cls == C_I: begin
          bus.aluop  = 2'b11;
          bus.alusrc = 2'b01;
        end
        cls == C_LOAD || cls == C_STORE: begin
          bus.alusrc = 2'b01;
        end
        cls == C_B: begin
          bus.aluop = 2'b01;
        end
        cls == C_JAL || cls == C_JALR: begin
          bus.alusrc = 2'b10;
        end
        cls == C_LUI || cls == C_AUIPC: begin
          bus.alusrc = 2'b11;
        end
        default: begin
          bus.aluop  = 2'b00;
          bus.alusrc = 2'b00;
        end
      endcase
    end
  end

  assign bus.fetch_req_o  = (state == S_FETCH);
  assign bus.ir_write     = !rst && state == S_FETCH &&
                            bus.imem_ready_i;
  assign bus.pc_write     = pc_wr;
  assign bus.branch       = in_x && cls == C_B;
  assign bus.jal          = in_x && cls == C_JAL;
  assign bus.jalr         = in_x && cls == C_JALR;
  assign bus.memread      = state == S_MEM && cls == C_LOAD;
  assign bus.memwrite     = state == S_MEM && cls == C_STORE;
  assign bus.regwrite     = (state == S_WB);
  assign bus.memtoreg     = state == S_WB && cls == C_LOAD;
  assign bus.state_o      = state;
  assign bus.trap_o       = (state == S_TRAP);
  assign bus.trap_cause_o = cause;
  assign bus.instret_o    = instret;

endmodule

// File: tb/tb_multicycle_core_control.sv
// Bench: directed trap/timeout/reset checks on one instance and a
// randomized scoreboard run against a per-instruction reference model.
module tb_multicycle_core_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  bit   mon_en = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  localparam int N_INSTR = 60;

  multicycle_core_control_if #(.CNT_W(4))  bus_a ();
  multicycle_core_control_if #(.CNT_W(32)) bus_b ();

  multicycle_core_control #(
    .ENABLE_UPPER(1'b1), .MEM_TIMEOUT(6), .CNT_W(4)
  ) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a.master));

  multicycle_core_control #(
    .ENABLE_UPPER(1'b0), .MEM_TIMEOUT(4), .CNT_W(32)
  ) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b.master));

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    bit       legal;
    bit       ld, st, b, j, jr, wb;
    int       base;
    logic [1:0] aluop, alusrc;
  } ref_t;

  function automatic ref_t ref_of(input logic [6:0] op, input bit up);
    ref_t r;
    r = '{default: 0};
    r.legal = 1'b1;
    case (op)
      7'b0110011: begin r.aluop = 2'd2; r.wb = 1; end
      7'b0010011: begin r.aluop = 2'd3; r.alusrc = 2'd1; r.wb = 1; end
      7'b0000011: begin r.alusrc = 2'd1; r.ld = 1; r.wb = 1; end
      7'b0100011: begin r.alusrc = 2'd1; r.st = 1; end
      7'b1100011: begin r.aluop = 2'd1; r.b = 1; end
      7'b1101111: begin r.alusrc = 2'd2; r.j = 1; r.wb = 1; end
      7'b1100111: begin r.alusrc = 2'd2; r.jr = 1; r.wb = 1; end
      7'b0110111, 7'b0010111: begin
        r.alusrc = 2'd3; r.wb = 1; r.legal = up;
      end
      default: r.legal = 1'b0;
    endcase
    // cycles with every ready on its first cycle
    r.base = r.b ? 3 : (r.ld ? 5 : 4);
    return r;
  endfunction

  typedef struct {
    int cycles, fetch_cyc, rd_cyc, wr_cyc;
    int rw, m2r, br, jl, jr;
    logic [1:0] aluop, alusrc;
    int instret;
    logic [6:0] op;
  } exp_t;

  exp_t q[$];

  int m_cyc, m_fetch, m_rd, m_wr, m_rw, m_m2r, m_br, m_jl, m_jr, m_ir;
  logic [1:0] m_aluop, m_alusrc;
  bit m_bad;

  task automatic mon_clear;
    m_cyc = 0; m_fetch = 0; m_rd = 0; m_wr = 0; m_rw = 0;
    m_m2r = 0; m_br = 0; m_jl = 0; m_jr = 0; m_ir = 0;
    m_aluop = 0; m_alusrc = 0; m_bad = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_a || !mon_en) begin
      mon_clear();
    end else begin
      m_cyc++;
      m_fetch += int'(bus_a.fetch_req_o);
      m_rd    += int'(bus_a.memread);
      m_wr    += int'(bus_a.memwrite);
      m_rw    += int'(bus_a.regwrite);
      m_m2r   += int'(bus_a.memtoreg);
      m_br    += int'(bus_a.branch);
      m_jl    += int'(bus_a.jal);
      m_jr    += int'(bus_a.jalr);
      m_ir    += int'(bus_a.ir_write);
      if (bus_a.state_o == 3'd2) begin
        m_aluop  = bus_a.aluop;
        m_alusrc = bus_a.alusrc;
      end else if (bus_a.state_o == 3'd3 || bus_a.state_o == 3'd4) begin
        if (bus_a.aluop != m_aluop || bus_a.alusrc != m_alusrc)
          m_bad = 1'b1;
      end else if (bus_a.aluop != 0 || bus_a.alusrc != 0) begin
        m_bad = 1'b1;
      end
      if (bus_a.trap_o) check("unexpected_trap", bus_a.trap_o, 0);
      if (bus_a.pc_write) begin
        check("sb_nonempty", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("cycles",   m_cyc,   e.cycles);
          check("fetch_cyc", m_fetch, e.fetch_cyc);
          check("ir_write", m_ir,    1);
          check("memread_cyc",  m_rd,  e.rd_cyc);
          check("memwrite_cyc", m_wr,  e.wr_cyc);
          check("regwrite", m_rw,    e.rw);
          check("memtoreg", m_m2r,   e.m2r);
          check("branch",   m_br,    e.br);
          check("jal",      m_jl,    e.jl);
          check("jalr",     m_jr,    e.jr);
          check("aluop",    m_aluop, e.aluop);
          check("alusrc",   m_alusrc, e.alusrc);
          check("alu_hold", m_bad,   0);
          check("instret",  bus_a.instret_o, e.instret);
        end
        mon_clear();
      end
    end
  end

  task automatic wait_a(input bit mem, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!mem && bus_a.fetch_req_o) begin ok = 1'b1; break; end
      if (mem && (bus_a.memread || bus_a.memwrite)) begin
        ok = 1'b1; break;
      end
      @(negedge clk);
    end
  endtask

  task automatic reset_b;
    rst_b = 1'b1;
    bus_b.imem_ready_i = 1'b0;
    bus_b.dmem_ready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b0;
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [6:0] ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011,
                          7'b0100011, 7'b1100011, 7'b1101111,
                          7'b1100111, 7'b0110111, 7'b0010111};

  initial begin
    bit ok;
    int bad;
    ref_t r;
    exp_t e;
    logic [6:0] op;
    int fw, mw;

    rst_a = 1'b1;
    bus_a.opcode_i = '0;
    bus_a.imem_ready_i = 1'b0;
    bus_a.dmem_ready_i = 1'b0;
    bus_b.opcode_i = '0;

    // reset state and an R-type on instance b
    reset_b();
    check("b_rst_state", bus_b.state_o, 0);
    check("b_rst_fetch_req", bus_b.fetch_req_o, 1);
    check("b_rst_instret", bus_b.instret_o, 0);
    check("b_rst_trap", {bus_b.trap_o, bus_b.trap_cause_o}, 0);
    check("b_rst_ctrl", {bus_b.ir_write, bus_b.pc_write, bus_b.branch,
      bus_b.jal, bus_b.jalr, bus_b.memread, bus_b.memwrite,
      bus_b.memtoreg, bus_b.regwrite, bus_b.aluop, bus_b.alusrc}, 0);
    bus_b.opcode_i = 7'b0110011;
    bus_b.imem_ready_i = 1'b1;
    #1 check("b_r_ir_write", bus_b.ir_write, 1);
    step(); bus_b.imem_ready_i = 1'b0;
    check("b_r_decode", bus_b.state_o, 1);
    step();
    check("b_r_exec", {bus_b.state_o, bus_b.aluop, bus_b.alusrc,
      bus_b.regwrite, bus_b.pc_write}, {3'd2, 2'b10, 2'b00, 2'b00});
    step();
    check("b_r_wb", {bus_b.state_o, bus_b.aluop, bus_b.alusrc,
      bus_b.regwrite, bus_b.pc_write}, {3'd4, 2'b10, 2'b00, 2'b11});
    step();
    check("b_r_instret", bus_b.instret_o, 1);
    check("b_r_back_fetch", bus_b.state_o, 0);

    // reset in the middle of a STORE's MEM state
    bus_b.opcode_i = 7'b0100011;
    bus_b.imem_ready_i = 1'b1;
    step(); bus_b.imem_ready_i = 1'b0;
    step(); step();
    check("b_st_mem", {bus_b.state_o, bus_b.memwrite}, {3'd3, 1'b1});
    rst_b = 1'b1;
    bus_b.dmem_ready_i = 1'b1;
    #1 check("b_st_rst_no_pcw", bus_b.pc_write, 0);
    step();
    check("b_st_rst", {bus_b.state_o, bus_b.memwrite}, 0);
    check("b_st_rst_instret", bus_b.instret_o, 0);
    rst_b = 1'b0;
    bus_b.dmem_ready_i = 1'b0;

    // LUI is illegal when upper decode is disabled
    bus_b.opcode_i = 7'b0110111;
    bus_b.imem_ready_i = 1'b1;
    step(); step();
    check("b_lui_trap", {bus_b.state_o, bus_b.trap_o, bus_b.trap_cause_o},
      {3'd5, 1'b1, 2'b01});
    check("b_trap_ctrl", {bus_b.fetch_req_o, bus_b.ir_write,
      bus_b.pc_write, bus_b.branch, bus_b.jal, bus_b.jalr,
      bus_b.memread, bus_b.memwrite, bus_b.memtoreg, bus_b.regwrite,
      bus_b.aluop, bus_b.alusrc}, 0);
    bad = 0;
    repeat (20) begin
      step();
      if (bus_b.state_o != 3'd5) bad++;
    end
    check("b_trap_sticky", bad, 0);
    reset_b();
    check("b_trap_rst", {bus_b.state_o, bus_b.trap_o}, 0);

    // fetch timeout at the 4th wait cycle
    step(); step(); step();
    check("b_fto_wait", bus_b.state_o, 0);
    step();
    check("b_fto_trap", {bus_b.state_o, bus_b.trap_cause_o},
      {3'd5, 2'b10});

    // ready on the limit cycle wins
    reset_b();
    step(); step(); step();
    bus_b.imem_ready_i = 1'b1;
    step();
    bus_b.imem_ready_i = 1'b0;
    check("b_fto_ready_wins", {bus_b.state_o, bus_b.trap_o},
      {3'd1, 1'b0});

    // data timeout on a LOAD
    reset_b();
    bus_b.opcode_i = 7'b0000011;
    bus_b.imem_ready_i = 1'b1;
    step(); bus_b.imem_ready_i = 1'b0;
    step(); step();
    check("b_ld_mem", {bus_b.state_o, bus_b.memread}, {3'd3, 1'b1});
    step(); step(); step();
    check("b_dto_wait", {bus_b.state_o, bus_b.memread}, {3'd3, 1'b1});
    step();
    check("b_dto_trap", {bus_b.state_o, bus_b.trap_cause_o,
      bus_b.memread}, {3'd5, 2'b11, 1'b0});

    // randomized scoreboard run on instance a
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < N_INSTR; i++) begin
      op = ops[$urandom_range(0, 8)];
      fw = $urandom_range(0, 5);
      mw = $urandom_range(0, 5);
      r = ref_of(op, 1'b1);
      e.op        = op;
      e.cycles    = r.base + fw + ((r.ld || r.st) ? mw : 0);
      e.fetch_cyc = fw + 1;
      e.rd_cyc    = r.ld ? mw + 1 : 0;
      e.wr_cyc    = r.st ? mw + 1 : 0;
      e.rw        = int'(r.wb);
      e.m2r       = int'(r.ld);
      e.br        = int'(r.b);
      e.jl        = r.j ? 2 : 0;
      e.jr        = r.jr ? 2 : 0;
      e.aluop     = r.aluop;
      e.alusrc    = r.alusrc;
      e.instret   = i % 16;
      wait_a(1'b0, ok);
      check("a_fetch_seen", ok, 1);
      if (!ok) break;
      q.push_back(e);
      bus_a.opcode_i = op;
      repeat (fw) begin
        bus_a.imem_ready_i = 1'b0;
        @(negedge clk);
      end
      bus_a.imem_ready_i = 1'b1;
      @(negedge clk);
      bus_a.imem_ready_i = 1'b0;
      if (r.ld || r.st) begin
        wait_a(1'b1, ok);
        check("a_mem_seen", ok, 1);
        if (!ok) break;
        repeat (mw) begin
          bus_a.dmem_ready_i = 1'b0;
          @(negedge clk);
        end
        bus_a.dmem_ready_i = 1'b1;
        @(negedge clk);
        bus_a.dmem_ready_i = 1'b0;
      end
    end
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    check("a_queue_drained", q.size(), 0);

    // illegal opcode on the upper-enabled instance
    mon_en = 1'b0;
    wait_a(1'b0, ok);
    check("a_fetch_before_ill", ok, 1);
    bus_a.opcode_i = 7'b1111111;
    bus_a.imem_ready_i = 1'b1;
    step(); bus_a.imem_ready_i = 1'b0;
    step();
    check("a_ill_trap", {bus_a.state_o, bus_a.trap_o, bus_a.trap_cause_o},
      {3'd5, 1'b1, 2'b01});
    check("a_ill_ctrl", {bus_a.fetch_req_o, bus_a.pc_write,
      bus_a.regwrite, bus_a.aluop, bus_a.alusrc}, 0);
    check("a_instret_wrap", bus_a.instret_o, N_INSTR % 16);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_core_control.md
# multicycle_core_control

Multi-cycle control sequencer for the RV32I core; the next generation of the single-cycle opcode decoder. It decodes the same opcode classes and produces the same control-signal set. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with ready/valid waits on instruction and data memory. It also adds optional LUI/AUIPC support, illegal-opcode and memory-timeout trapping, and a retired-instruction counter. It sits between the instruction register and the shared-memory multi-cycle datapath.

## Interface

Parameters:
- ENABLE_UPPER, default 1: decode LUI (0110111) and AUIPC (0010111); 0 = treat them as illegal.
- MEM_TIMEOUT, default 255: maximum wait cycles for a ready; 0 disables the timeout.
- CNT_W, default 32: width of the retire counter.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- opcode_i, input, 7: opcode field from the instruction register; valid from DECODE onward.
- imem_ready_i, input, 1: instruction fetch complete.
- dmem_ready_i, input, 1: data access complete.
- fetch_req_o, output, 1: instruction fetch request.
- ir_write, output, 1: load the instruction register.
- pc_write, output, 1: update the PC; the datapath selects the target.
- branch, jal, jalr, output, 1 each: class flags.
- memread, memwrite, memtoreg, regwrite, output, 1 each: datapath controls.
- aluop, output, 2: 00 = LSJ/upper, 01 = B, 10 = R, 11 = I.
- alusrc, output, 2: 00 = rs2, 01 = imm, 10 = PC+4 path, 11 = upper-imm path.
- state_o, output, 3: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- trap_o, output, 1: in TRAP.
- trap_cause_o, output, 2: 01 = illegal, 10 = fetch timeout, 11 = data timeout.
- instret_o, output, CNT_W: retired instruction count.

## Operation

- The opcode class is latched once in DECODE into a class register. branch, jal, jalr, aluop and alusrc come from that register, not from opcode_i.
- FETCH: fetch_req_o=1. When imem_ready_i=1, ir_write=1 in the same cycle and the next state is DECODE.
- DECODE: one cycle; latch the class.
  - Unknown opcode, or upper opcode with ENABLE_UPPER=0 → TRAP, cause 01.
  - Otherwise → EXEC.
- EXEC: one cycle; aluop and alusrc are driven.
  - B: branch=1, pc_write=1 → FETCH.
  - LOAD or STORE → MEM.
  - R, I, JAL, JALR, LUI, AUIPC → WB.
- MEM: memread=1 (LOAD) or memwrite=1 (STORE), held until dmem_ready_i=1.
  - On ready, LOAD → WB.
  - On ready, STORE asserts pc_write=1 that cycle → FETCH.
- WB: regwrite=1 and pc_write=1 → FETCH. memtoreg=1 only for LOAD.
- branch, jal and jalr are held from EXEC through the last state of the instruction.
- aluop and alusrc are held in EXEC, MEM and WB and are 00 in FETCH, DECODE and TRAP.
- Class encodings:
  - R: aluop 10, alusrc 00.
  - I: aluop 11, alusrc 01.
  - LOAD and STORE: aluop 00, alusrc 01.
  - B: aluop 01, alusrc 00.
  - JAL and JALR: aluop 00, alusrc 10.
  - LUI and AUIPC: aluop 00, alusrc 11.
- Timeout: a wait counter clears on entry to FETCH and MEM and increments each cycle without ready. When it reaches MEM_TIMEOUT with no ready → TRAP, cause 10 (FETCH) or 11 (MEM). A ready in the same cycle as the limit wins.
- TRAP: all control outputs 0, trap_o=1, cause held. TRAP is left only via rst.
- instret_o increments by 1 on every pc_write cycle and wraps modulo 2^CNT_W.

## Timing

- Reset: state FETCH; instret_o, trap_cause_o, the class register and the wait counter are 0. Every output is 0 except fetch_req_o, which is 1 from the first cycle after reset.
- Reset takes priority over all events. Reset in MEM drops memread/memwrite on the next edge; no pc_write and no count.
- ir_write, pc_write in MEM, and the memread/memwrite drop are Mealy on the ready inputs. All other outputs are Moore, decoded from the state and class registers.
- Latency with ready on the first cycle:
  - B: 3 cycles.
  - STORE: 4 cycles.
  - R, I, JAL, JALR, LUI, AUIPC: 4 cycles.
  - LOAD: 5 cycles.
  - Each extra wait cycle adds 1.
- Ready inputs are ignored outside FETCH (imem) and MEM (dmem).
- opcode_i is sampled only in DECODE.

## Test plan

- Reset, then R-type 0110011 with imem_ready_i=1 → states 0,1,2,4. regwrite and pc_write both 1 only in WB. aluop=10, alusrc=00 in EXEC/WB. instret_o=1 after 4 cycles.
- LOAD 0000011 with dmem_ready_i held 0 for 3 cycles in MEM → memread high for 4 cycles. Then WB with memtoreg=1, regwrite=1. Total 8 cycles; instret_o=1.
- B 1100011, then STORE 0100011 back-to-back → B has pc_write in EXEC (cycle 3). STORE has memwrite in MEM and pc_write on ready, regwrite=0. instret_o=2 after 7 cycles.
- Opcode 1111111, then ENABLE_UPPER=0 with LUI → TRAP, cause 01, all controls 0. The state stays 5 for 20 cycles with imem_ready_i=1; only rst restores FETCH.
- MEM_TIMEOUT=4, imem_ready_i stuck 0 → TRAP at the 4th wait cycle, cause 10. Repeat with ready on that same cycle → DECODE, no trap.
- CNT_W=4: retire 17 I-type (0010011) instructions → instret_o=1. Assert rst mid-MEM of a STORE → memwrite 0 next cycle, instret_o=0, state FETCH.
